fpu_add_arbiter: RTL

Shares one multi-cycle `add_float` instance between `NUM_REQ` independent requesters.
- Arbitrates requests round-robin and holds the winner's operands stable for the whole adder operation.
- Issues a single-cycle `start`, waits for the adder's `done` handshake and returns the result tagged with the requester index.
- Sits between FPU clients (e.g. a dot-product sequencer or instruction issue) and the adder; exactly one operation is in flight at a time.

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fpu_add_arbiter_rr_arbiter.sv | 50 +++++
 rtl/fpu_add_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared definitions for the FPU blocks: the adder-arbiter FSM
//               state encoding, the index of each bit in the 4-bit status
//               flag vector, and the NaN/Inf encodings used across the FPU.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  // Adder arbiter FSM states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_CLR = 3'd2,
    S_WAIT_SET = 3'd3,
    S_RESP     = 3'd4
  } arb_state_t;

  // Bit positions inside the {nan, overflow, underflow, zero} flag vector
  localparam int c_FLAG_NAN  = 3;
  localparam int c_FLAG_OVF  = 2;
  localparam int c_FLAG_UNF  = 1;
  localparam int c_FLAG_ZERO = 0;

  // Canonical special values
  localparam logic [63:0] c_QNAN64 = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] c_PINF64 = 64'h7FF0_0000_0000_0000;
  localparam logic [31:0] c_QNAN32 = 32'h7FC0_0000;
  localparam logic [31:0] c_PINF32 = 32'h7F80_0000;

endpackage
`default_nettype wire

// File: rtl/fpu_add_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant. Picks the first asserted
//               request at or above ptr, wrapping around to index 0.
// Ports       : req          - request vector, one bit per requester
//               ptr          - highest-priority index for this decision
//               grant_onehot - one-hot winner (all zero when no request)
//               grant_id     - binary index of the winner
//               any          - at least one request is asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant_onehot,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                any
);

  logic w_found;

  // Two passes: first the indices at or above ptr, then the wrapped-around
  // lower indices. The first hit wins, which gives the circular search.
  always_comb begin
    w_found      = 1'b0;
    grant_onehot = '0;
    grant_id     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[i] && (i >= int'(ptr))) begin
        w_found         = 1'b1;
        grant_onehot[i] = 1'b1;
        grant_id        = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[i] && (i < int'(ptr))) begin
        w_found         = 1'b1;
        grant_onehot[i] = 1'b1;
        grant_id        = ID_WIDTH'(i);
      end
    end
    any = w_found;
  end

endmodule
`default_nettype wire

// File: rtl/fpu_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_add_arbiter
// Description : Shares one multi-cycle floating-point adder between NUM_REQ
//               requesters. Round-robin grant, operands held for the whole
//               operation, single-cycle start pulse, done handshake with
//               stale-done rejection, timeout abort, tagged response.
// Ports       : clk, rst                 - clock / synchronous active-high reset
//               req_valid/req_ready      - per-requester handshake
//               req_op_sub, req_op1/2    - packed per-requester operands
//               add_start, add_op_sub,
//               add_op1/2                - adder command (held operands)
//               add_out, add_nan/...,
//               add_done                 - adder result and done level
//               resp_valid/resp_ready    - response handshake
//               resp_id, resp_out,
//               resp_flags, resp_timeout - response payload
//               busy                     - FSM not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_add_arbiter
  import fpu_pkg::*;
#(
  parameter int FLOAT_WIDTH = 64,
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_op_sub,
  input  logic [NUM_REQ*FLOAT_WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*FLOAT_WIDTH-1:0] req_op2,
  output logic                           add_start,
  output logic                           add_op_sub,
  output logic [FLOAT_WIDTH-1:0]         add_op1,
  output logic [FLOAT_WIDTH-1:0]         add_op2,
  input  logic [FLOAT_WIDTH-1:0]         add_out,
  input  logic                           add_nan,
  input  logic                           add_overflow,
  input  logic                           add_underflow,
  input  logic                           add_zero,
  input  logic                           add_done,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [ID_WIDTH-1:0]            resp_id,
  output logic [FLOAT_WIDTH-1:0]         resp_out,
  output logic [3:0]                     resp_flags,
  output logic                           resp_timeout,
  output logic                           busy
);

  localparam int c_CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t             r_state;
  logic [ID_WIDTH-1:0]    r_ptr;
  logic [ID_WIDTH-1:0]    r_id;
  logic                   r_start;
  logic                   r_op_sub;
  logic [FLOAT_WIDTH-1:0] r_op1;
  logic [FLOAT_WIDTH-1:0] r_op2;
  logic                   r_resp_valid;
  logic [FLOAT_WIDTH-1:0] r_resp_out;
  logic [3:0]             r_resp_flags;
  logic                   r_resp_timeout;
  logic [c_CNT_W-1:0]     r_cnt;

  logic [NUM_REQ-1:0]     w_grant_oh;
  logic [ID_WIDTH-1:0]    w_grant_id;
  logic                   w_any;
  logic [ID_WIDTH-1:0]    w_ptr_next;
  logic                   w_sel_sub;
  logic [FLOAT_WIDTH-1:0] w_sel_op1;
  logic [FLOAT_WIDTH-1:0] w_sel_op2;
  logic [c_CNT_W-1:0]     w_cnt_next;
  logic                   w_timeout;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req          (req_valid),
    .ptr          (r_ptr),
    .grant_onehot (w_grant_oh),
    .grant_id     (w_grant_id),
    .any          (w_any)
  );

  // Winner's operands, selected by the one-hot grant
  always_comb begin
    w_sel_sub = 1'b0;
    w_sel_op1 = '0;
    w_sel_op2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_oh[i]) begin
        w_sel_sub = req_op_sub[i];
        w_sel_op1 = req_op1[i*FLOAT_WIDTH +: FLOAT_WIDTH];
        w_sel_op2 = req_op2[i*FLOAT_WIDTH +: FLOAT_WIDTH];
      end
    end
  end

  assign w_ptr_next = (w_grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;

  // The abort fires in the cycle where the counter would step onto TIMEOUT,
  // so the response appears exactly TIMEOUT cycles after WAIT_CLR is entered
  // and the counter itself tops out at TIMEOUT without wrapping.
  assign w_cnt_next = r_cnt + 1'b1;
  assign w_timeout  = (w_cnt_next == c_CNT_W'(TIMEOUT));

  // req_ready must coincide with the grant decision so the requester sees
  // its accept in the same cycle its request is taken; it is therefore a
  // decode of the registered state and the arbiter, not a flop.
  assign req_ready = ((r_state == S_IDLE) && !rst) ? w_grant_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_id           <= '0;
      r_start        <= 1'b0;
      r_op_sub       <= 1'b0;
      r_op1          <= '0;
      r_op2          <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_out     <= '0;
      r_resp_flags   <= '0;
      r_resp_timeout <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op_sub <= w_sel_sub;
            r_op1    <= w_sel_op1;
            r_op2    <= w_sel_op2;
            r_id     <= w_grant_id;
            r_ptr    <= w_ptr_next;
            r_start  <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_CLR;
        end

        // A done level left high by the previous operation must be seen
        // low before a rising done is trusted as this operation's result.
        S_WAIT_CLR: begin
          r_cnt <= w_cnt_next;
          if (w_timeout) begin
            r_resp_out     <= '0;
            r_resp_flags   <= '0;
            r_resp_timeout <= 1'b1;
            r_resp_valid   <= 1'b1;
            r_state        <= S_RESP;
          end else if (!add_done) begin
            r_state <= S_WAIT_SET;
          end
        end

        S_WAIT_SET: begin
          r_cnt <= w_cnt_next;
          if (w_timeout) begin
            r_resp_out     <= '0;
            r_resp_flags   <= '0;
            r_resp_timeout <= 1'b1;
            r_resp_valid   <= 1'b1;
            r_state        <= S_RESP;
          end else if (add_done) begin
            r_resp_out                <= add_out;
            r_resp_flags[c_FLAG_NAN]  <= add_nan;
            r_resp_flags[c_FLAG_OVF]  <= add_overflow;
            r_resp_flags[c_FLAG_UNF]  <= add_underflow;
            r_resp_flags[c_FLAG_ZERO] <= add_zero;
            r_resp_timeout            <= 1'b0;
            r_resp_valid              <= 1'b1;
            r_state                   <= S_RESP;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign add_start    = r_start;
  assign add_op_sub   = r_op_sub;
  assign add_op1      = r_op1;
  assign add_op2      = r_op2;
  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_id;
  assign resp_out     = r_resp_out;
  assign resp_flags   = r_resp_flags;
  assign resp_timeout = r_resp_timeout;
  assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire
